// File: rtl/lru_pkg.sv
// Shared LRU types: per-set state record, command encoding and reset helper.
// Optional hit/miss statistics in the tracker are enabled with LRU_STATS_EN.
package lru_pkg;

  localparam int MAX_WAYS  = 16;
  localparam int MAX_WAY_W = 4;

  // Sized for the largest supported associativity so the cache controller's
  // debug view can use the same record regardless of WAYS.
  typedef struct packed {
    logic [MAX_WAYS-1:0][MAX_WAY_W-1:0] age;
    logic [MAX_WAYS-1:0]                valid;
  } lru_set_state_t;

  typedef enum logic [1:0] {
    CMD_NONE  = 2'd0,
    CMD_TOUCH = 2'd1,
    CMD_INV   = 2'd2
  } lru_cmd_e;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic lru_set_state_t lru_reset_state(input int ways);
    lru_set_state_t s;
    s = '0;
    for (int w = 0; w < MAX_WAYS; w++) begin
      if (w < ways) s.age[w] = MAX_WAY_W'(w);
    end
    return s;
  endfunction

endpackage

// File: rtl/lru_nway_tracker_if.sv
// Access/victim bus between the cache controller (master) and the LRU tracker (slave).
// Counter fields carry data only when the tracker is built with LRU_STATS_EN.
interface lru_nway_tracker_if
  import lru_pkg::*;
#(
  parameter int WAYS = 4,
  parameter int SETS = 4
);
  localparam int WAY_W = $clog2(WAYS);
  localparam int SET_W = clog2_min1(SETS);

  logic             enable;
  logic             hit;
  logic             inv;
  logic [SET_W-1:0] setIndex;
  logic [WAY_W-1:0] lineIndex;
  logic [WAY_W-1:0] lruOut;
  logic             lruValid;
  logic [31:0]      hitCount;
  logic [31:0]      missCount;

  modport master (
    output enable, hit, inv, setIndex, lineIndex,
    input  lruOut, lruValid, hitCount, missCount
  );

  modport slave (
    input  enable, hit, inv, setIndex, lineIndex,
    output lruOut, lruValid, hitCount, missCount
  );

endinterface

// File: rtl/lru_set_update.sv
// Combinational next-state and victim logic for one set of the LRU tracker.
// Ages form a permutation of 0..WAYS-1 (0 = MRU); touch and invalidate preserve it.
module lru_set_update
  import lru_pkg::*;
#(
  parameter  int WAYS  = 4,
  localparam int WAY_W = $clog2(WAYS)
) (
  input  lru_set_state_t   state_i,
  input  lru_cmd_e         cmd_i,
  input  logic [WAY_W-1:0] way_i,
  output lru_set_state_t   state_o,
  output logic [WAY_W-1:0] victim_o,
  output logic             all_valid_o
);

  localparam logic [WAY_W-1:0] AGE_LRU = WAY_W'(WAYS - 1);

  logic [WAY_W-1:0] ref_age;

  assign all_valid_o = &state_i.valid[WAYS-1:0];
  assign ref_age     = state_i.age[way_i][WAY_W-1:0];

  always_comb begin
    // NOTE: every output gets a default before any branch so no path can leave it unassigned and infer a latch.
    victim_o = '0;
    if (all_valid_o) begin
      for (int w = 0; w < WAYS; w++) begin
        if (state_i.age[w][WAY_W-1:0] == AGE_LRU) victim_o = WAY_W'(w);
      end
    end else begin
      // Descending scan so the lowest-index invalid way wins.
      for (int w = WAYS - 1; w >= 0; w--) begin
        if (!state_i.valid[w]) victim_o = WAY_W'(w);
      end
    end
  end

  always_comb begin
    state_o = state_i;
    unique case (cmd_i)
      CMD_TOUCH: begin
        for (int v = 0; v < WAYS; v++) begin
          if (state_i.age[v][WAY_W-1:0] < ref_age)
            state_o.age[v] = MAX_WAY_W'(state_i.age[v][WAY_W-1:0] + 1'b1);
        end
        state_o.age[way_i]   = '0;
        state_o.valid[way_i] = 1'b1;
      end
      CMD_INV: begin
        for (int v = 0; v < WAYS; v++) begin
          if (state_i.age[v][WAY_W-1:0] > ref_age)
            state_o.age[v] = MAX_WAY_W'(state_i.age[v][WAY_W-1:0] - 1'b1);
        end
        state_o.age[way_i]   = MAX_WAY_W'(AGE_LRU);
        state_o.valid[way_i] = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lru_nway_tracker.sv
// WAYS x SETS LRU replacement tracker with valid bits and invalid-first victim choice.
// Define LRU_STATS_EN to build the saturating hit/miss counters; otherwise they read 0.
module lru_nway_tracker
  import lru_pkg::*;
#(
  parameter  int WAYS  = 4,
  parameter  int SETS  = 4,
  localparam int WAY_W = $clog2(WAYS),
  localparam int SET_W = clog2_min1(SETS)
) (
  input  logic              clk,
  input  logic              reset,
  lru_nway_tracker_if.slave bus
);

  lru_set_state_t   state_q [SETS];
  lru_set_state_t   state_d [SETS];
  lru_set_state_t   next_state;
  lru_cmd_e         cmd;
  logic [SET_W-1:0] set_sel;
  logic [WAY_W-1:0] way;
  logic [WAY_W-1:0] victim;
  logic             all_valid;

  // With a single set the index port is a dummy bit; always address entry 0.
  assign set_sel = (SETS > 1) ? bus.setIndex : '0;

  // Invalidate wins over a simultaneous access; the access is dropped.
  always_comb begin
    cmd = CMD_NONE;
    if (bus.inv)         cmd = CMD_INV;
    else if (bus.enable) cmd = CMD_TOUCH;
  end

  assign way = (bus.inv || bus.hit) ? bus.lineIndex : victim;

  lru_set_update #(.WAYS(WAYS)) u_set_update (
    .state_i     (state_q[set_sel]),
    .cmd_i       (cmd),
    .way_i       (way),
    .state_o     (next_state),
    .victim_o    (victim),
    .all_valid_o (all_valid)
  );

  always_comb begin
    state_d = state_q;
    if (cmd != CMD_NONE) state_d[set_sel] = next_state;
  end

  // NOTE: this state array is reset on purpose -- the age permutation must start defined, so it cannot be mapped to an unreset RAM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++) state_q[s] <= lru_reset_state(WAYS);
    end else begin
      // NOTE: state registers take non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
    end
  end

  assign bus.lruOut   = victim;
  assign bus.lruValid = all_valid;

`ifdef LRU_STATS_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;

  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (cmd == CMD_TOUCH) begin
      if (bus.hit && (hit_count_q != '1))   hit_count_d  = hit_count_q + 32'd1;
      if (!bus.hit && (miss_count_q != '1)) miss_count_d = miss_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign bus.hitCount  = hit_count_q;
  assign bus.missCount = miss_count_q;
`else
  assign bus.hitCount  = '0;
  assign bus.missCount = '0;
`endif

endmodule

// File: tb/tb_lru_nway_tracker.sv
// Directed bench for lru_nway_tracker (WAYS=4, SETS=4); counter expectations follow LRU_STATS_EN.
module tb_lru_nway_tracker;
  import lru_pkg::*;

`ifdef LRU_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  lru_nway_tracker_if #(.WAYS(4), .SETS(4)) bus ();

  lru_nway_tracker #(.WAYS(4), .SETS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: observed no finish, expected finish before 50000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic en, input logic h, input logic iv,
                       input logic [1:0] set, input logic [1:0] line);
    bus.enable    = en;
    bus.hit       = h;
    bus.inv       = iv;
    bus.setIndex  = set;
    bus.lineIndex = line;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ecnt(input int n);
    return STATS ? 32'(n) : 32'd0;
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 2'd2, 2'd0);
    #10;
    check("reset_lru",   32'(bus.lruOut), 32'd0);
    check("reset_valid", 32'(bus.lruValid), 32'd0);
    check("reset_hits",  bus.hitCount, 32'd0);
    check("reset_miss",  bus.missCount, 32'd0);
    reset = 1'b0;

    // Fill set 2 with four misses: victim walks 0,1,2,3.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b0, 2'd2, 2'd0);
      check($sformatf("fill_victim%0d", i), 32'(bus.lruOut), 32'(i));
      check($sformatf("fill_notfull%0d", i), 32'(bus.lruValid), 32'd0);
      tick();
    end
    check("full_valid", 32'(bus.lruValid), 32'd1);
    check("full_lru",   32'(bus.lruOut), 32'd0);

    // Fifth miss evicts way 0 -> ages 0,3,2,1; LRU is way 1.
    tick();
    check("miss5_lru", 32'(bus.lruOut), 32'd1);

    // Hit way 0 (ages unchanged), then way 1 -> ages 1,0,3,2.
    drive(1'b1, 1'b1, 1'b0, 2'd2, 2'd0);
    tick();
    check("hit0_lru", 32'(bus.lruOut), 32'd1);
    drive(1'b1, 1'b1, 1'b0, 2'd2, 2'd1);
    tick();
    check("hit1_lru", 32'(bus.lruOut), 32'd2);
    check("hit_cnt2", bus.hitCount, ecnt(2));
    check("miss_cnt5", bus.missCount, ecnt(5));

    // Idle with lineIndex toggling: nothing moves.
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0, 2'd2, (i % 2 == 0) ? 2'd3 : 2'd1);
      tick();
      check($sformatf("idle_lru%0d", i), 32'(bus.lruOut), 32'd2);
      check($sformatf("idle_valid%0d", i), 32'(bus.lruValid), 32'd1);
    end
    check("idle_hits", bus.hitCount, ecnt(2));

    // Invalidate way 3 (age 2): ages become 1,0,2,3.
    drive(1'b0, 1'b0, 1'b1, 2'd2, 2'd3);
    check("inv_pre_lru", 32'(bus.lruOut), 32'd2);
    tick();
    check("inv_lru",   32'(bus.lruOut), 32'd3);
    check("inv_valid", 32'(bus.lruValid), 32'd0);

    // inv with an access in the same cycle: access dropped.
    drive(1'b1, 1'b1, 1'b1, 2'd2, 2'd3);
    tick();
    check("invacc_lru",  32'(bus.lruOut), 32'd3);
    check("invacc_hits", bus.hitCount, ecnt(2));
    check("invacc_miss", bus.missCount, ecnt(5));

    // Hit on invalid way 3 validates it: ages 2,1,3,0 -> LRU way 2.
    drive(1'b1, 1'b1, 1'b0, 2'd2, 2'd3);
    tick();
    check("hitinv_lru",   32'(bus.lruOut), 32'd2);
    check("hitinv_valid", 32'(bus.lruValid), 32'd1);
    check("hitinv_hits",  bus.hitCount, ecnt(3));

    // Other sets are untouched; a miss in set 1 leaves set 2 intact.
    drive(1'b0, 1'b0, 1'b0, 2'd1, 2'd0);
    check("set1_lru",   32'(bus.lruOut), 32'd0);
    check("set1_valid", 32'(bus.lruValid), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 2'd1, 2'd0);
    tick();
    check("set1_miss_lru", 32'(bus.lruOut), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 2'd2, 2'd0);
    check("set2_kept_lru",   32'(bus.lruOut), 32'd2);
    check("set2_kept_valid", 32'(bus.lruValid), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    check("set0_lru",  32'(bus.lruOut), 32'd0);
    check("miss_cnt6", bus.missCount, ecnt(6));

    // Asynchronous reset between edges while an access is pending.
    drive(1'b1, 1'b0, 1'b0, 2'd2, 2'd0);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_lru",   32'(bus.lruOut), 32'd0);
    check("midrst_valid", 32'(bus.lruValid), 32'd0);
    check("midrst_hits",  bus.hitCount, 32'd0);
    check("midrst_miss",  bus.missCount, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    reset = 1'b0;

    // Set 0: miss, miss, hit 0, hit 1, hit 2 -> way 3 still invalid.
    drive(1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b0, 2'd0, 2'(i));
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    check("post_lru",   32'(bus.lruOut), 32'd3);
    check("post_valid", 32'(bus.lruValid), 32'd0);
    check("post_hits",  bus.hitCount, ecnt(3));
    check("post_miss",  bus.missCount, ecnt(2));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
